// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map, column reset pattern.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } keypad_state_t;

    localparam logic [3:0] KEY_STAR  = 4'hE;
    localparam logic [3:0] KEY_HASH  = 4'hF;
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed {row, col}; entry 15 (row3, col3) is listed first.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, KEY_HASH, 4'h0, KEY_STAR,
        4'hC, 4'h9,     4'h8, 4'h7,
        4'hB, 4'h6,     4'h5, 4'h4,
        4'hA, 4'h3,     4'h2, 4'h1
    };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable synchronous reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: column drive, row debounce, key encoding, one key_valid pulse per press.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 20000
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 5000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_CNT);
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt;
`endif

    logic [3:0]    rs;
    keypad_state_t state;
    logic [DW-1:0] dwell;
    logic [CW-1:0] cnt;
    logic [1:0]    row_sel;
    logic [1:0]    col_sel;
    logic          row_high;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (rs)
    );

    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        if (!rows[0])      return 2'd0;
        else if (!rows[1]) return 2'd1;
        else if (!rows[2]) return 2'd2;
        else               return 2'd3;
    endfunction

    function automatic logic [3:0] rotate_col(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

    assign row_high = rs[row_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            dwell       <= '0;
            cnt         <= '0;
            row_sel     <= 2'd0;
            col_sel     <= 2'd0;
            col_out     <= COL_RESET;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
            unique case (state)
                SCAN: begin
                    // Rows are only trusted at the end of the dwell, once the synchronizer has settled.
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (rs != 4'b1111) begin
                            row_sel <= lowest_low(rs);
                            cnt     <= CW'(1);
                            state   <= DEBOUNCE;
                        end else begin
                            col_sel <= col_sel + 2'd1;
                            col_out <= rotate_col(col_out);
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end

                DEBOUNCE: begin
                    if (row_high) begin
                        dwell   <= '0;
                        col_sel <= col_sel + 2'd1;
                        col_out <= rotate_col(col_out);
                        state   <= SCAN;
                    end else if (cnt == DB_MAX) begin
                        key_code    <= KEY_MAP[{row_sel, col_sel}];
                        key_valid   <= 1'b1;
                        key_pressed <= 1'b1;
                        cnt         <= '0;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                HOLD: begin
                    if (row_high) begin
                        cnt   <= CW'(1);
                        state <= RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_cnt == REP_LAST) begin
                        key_valid <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + RW'(1);
                    end
`endif
                end

                RELEASE: begin
                    if (!row_high) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else if (cnt == DB_MAX) begin
                        key_pressed <= 1'b0;
                        cnt         <= '0;
                        dwell       <= '0;
                        col_sel     <= col_sel + 2'd1;
                        col_out     <= rotate_col(col_out);
                        state       <= SCAN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural keypad model (SCAN_DIV=4, DEBOUNCE_CNT=8).
module tb_keypad_matrix_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    logic [15:0] keys;
    logic        force_en;
    logic [3:0]  force_rows;
    logic [3:0]  model_rows;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    logic [3:0] last_code = 4'h0;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
        logic [1:0]  col;
        string       name;
    } vec_t;

    vec_t vecs [7];

    keypad_matrix_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_CYCLES(20)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        model_rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) model_rows[r] = 1'b0;
    end

    assign row_in = force_en ? force_rows : model_rows;

    always @(negedge clk) begin
        if (key_valid) begin
            pulses    <= pulses + 1;
            last_code <= key_code;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1);
            found = key_valid;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         found;
        int         pbase;
        logic [3:0] exp_col;
        logic [1:0] nc;

        vecs[0] = '{16'h0020, 4'h5, 2'd1, "key_5"};
        vecs[1] = '{16'h1000, 4'hE, 2'd0, "key_star"};
        vecs[2] = '{16'h4000, 4'hF, 2'd2, "key_hash"};
        vecs[3] = '{16'h8000, 4'hD, 2'd3, "key_D"};
        vecs[4] = '{16'h0202, 4'h2, 2'd1, "rows0_2_col1"};
        vecs[5] = '{16'h0008, 4'hA, 2'd3, "key_A"};
        vecs[6] = '{16'h2000, 4'h0, 2'd1, "key_0"};

        keys       = 16'h0;
        force_en   = 1'b0;
        force_rows = 4'hF;

        // Reset values and idle column rotation
        do_reset(3);
        check("reset_key_code", key_code, 4'h0);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_key_pressed", key_pressed, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick(1);
            exp_col = 4'b1111;
            exp_col[(k / 4) % 4] = 1'b0;
            check($sformatf("idle_col_%0d", k), col_out, exp_col);
        end

        // Short bounce on row0/col0: captured, then abandoned without a pulse
        do_reset(1);
        pbase      = pulses;
        force_en   = 1'b1;
        force_rows = 4'b1110;
        tick(3);
        force_rows = 4'b1111;
        tick(1);
        check("bounce_col_frozen", col_out, 4'b1110);
        tick(2);
        check("bounce_next_col", col_out, 4'b1101);
        check("bounce_key_code", key_code, 4'h0);
        check("bounce_key_pressed", key_pressed, 1'b0);
        tick(4);
        check("bounce_scan_resumes", col_out, 4'b1011);
        check("bounce_no_pulse", pulses - pbase, 0);
        force_en = 1'b0;

        // Table of single presses
        foreach (vecs[i]) begin
            pbase = pulses;
            keys  = vecs[i].keys;
            wait_valid(found);
            check({vecs[i].name, "_seen"}, found, 1'b1);
            check({vecs[i].name, "_code"}, key_code, vecs[i].code);
            check({vecs[i].name, "_pressed"}, key_pressed, 1'b1);
            tick(15);
            check({vecs[i].name, "_pulses"}, pulses - pbase, 1);
            check({vecs[i].name, "_code_held"}, key_code, vecs[i].code);
            keys = 16'h0;
            tick(10);
            check({vecs[i].name, "_still_pressed"}, key_pressed, 1'b1);
            tick(1);
            check({vecs[i].name, "_released"}, key_pressed, 1'b0);
            nc      = vecs[i].col + 2'd1;
            exp_col = 4'b1111;
            exp_col[nc] = 1'b0;
            check({vecs[i].name, "_next_col"}, col_out, exp_col);
            tick(6);
        end

        // Reset while a key is held
        pbase = pulses;
        keys  = 16'h0100;
        wait_valid(found);
        check("hold_rst_seen", found, 1'b1);
        check("hold_rst_code_before", key_code, 4'h7);
        tick(5);
        rst  = 1'b1;
        keys = 16'h0;
        tick(1);
        rst = 1'b0;
        check("hold_rst_key_code", key_code, 4'h0);
        check("hold_rst_key_pressed", key_pressed, 1'b0);
        check("hold_rst_key_valid", key_valid, 1'b0);
        check("hold_rst_col", col_out, 4'b1110);
        tick(40);
        check("hold_rst_pulses", pulses - pbase, 1);

        // Reset during a partially debounced press
        do_reset(1);
        pbase      = pulses;
        force_en   = 1'b1;
        force_rows = 4'b1110;
        tick(6);
        rst        = 1'b1;
        force_rows = 4'b1111;
        tick(1);
        rst = 1'b0;
        check("deb_rst_col", col_out, 4'b1110);
        check("deb_rst_key_pressed", key_pressed, 1'b0);
        check("deb_rst_key_valid", key_valid, 1'b0);
        tick(40);
        check("deb_rst_no_pulse", pulses - pbase, 0);
        check("deb_rst_key_code", key_code, 4'h0);
        force_en = 1'b0;

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat while '9' is held
        pbase = pulses;
        keys  = 16'h0400;
        wait_valid(found);
        check("repeat_seen", found, 1'b1);
        tick(70);
        check("repeat_pulses", pulses - pbase, 4);
        check("repeat_code", last_code, 4'h9);
        keys = 16'h0;
        tick(20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
